// File: rtl/dma_write_logic.sv
// dma_write_logic: drains a first-word-fall-through FIFO into memory through an arbitrated bus, one word per granted cycle.
module dma_write_logic #(
    parameter int ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ctrl_sig_reg,
    input  logic [31:0] addr_reg,
    input  logic [31:0] count_reg,
    output logic        mem_request,
    input  logic        mem_grant,
    output logic [31:0] mem_addr,
    output logic        tx_enable,
    output logic [31:0] mem_wr_data,
    input  logic        empty,
    output logic        rd_enable,
    input  logic [31:0] rd_data,
    output logic        tx_done,
    output logic [31:0] words_left
);
    typedef enum logic [1:0] {IDLE, BUS_REQ, WRITE_DATA, DONE} state_t;
    state_t      state;
    logic [31:0] cur_addr;
    logic [31:0] cur_count;
    logic        armed;
    logic        run;
    logic        start;
    logic        xfer;
    assign run   = ctrl_sig_reg[0] & ctrl_sig_reg[1];
    // armed gives edge semantics to a level-held dma_active
    assign start = state == IDLE && run && armed;
    assign xfer  = state == WRITE_DATA && run && mem_grant && !empty;
    assign mem_request = state == BUS_REQ || state == WRITE_DATA;
    assign mem_addr    = state == WRITE_DATA ? cur_addr : '0;
    assign tx_enable   = xfer;
    assign rd_enable   = xfer;
    assign mem_wr_data = xfer ? rd_data : '0;
    assign words_left  = cur_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            cur_count <= '0;
            tx_done   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            armed <= start ? 1'b0 : (!ctrl_sig_reg[0] ? 1'b1 : armed);
            case (state)
                IDLE: if (start) begin
                    cur_addr  <= addr_reg;
                    cur_count <= count_reg;
                    tx_done   <= 1'b0;
                    state     <= count_reg == '0 ? DONE : BUS_REQ;
                end
                BUS_REQ: state <= !run ? IDLE : (mem_grant ? WRITE_DATA : BUS_REQ);
                WRITE_DATA: begin
                    if (!run) state <= IDLE;
                    else if (!mem_grant) state <= BUS_REQ;
                    else if (xfer) begin
                        cur_count <= cur_count - 32'd1;
                        cur_addr  <= cur_addr + (ctrl_sig_reg[2] ? 32'(ADDR_STEP) : 32'd0);
                        if (cur_count == 32'd1) state <= DONE;
                    end
                end
                DONE: begin
                    tx_done <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_write_logic.sv
// tb_dma_write_logic: directed cycle-by-cycle checks of the DMA write engine.
module tb_dma_write_logic;
    logic        clk = 0;
    logic        reset;
    logic [31:0] ctrl_sig_reg, addr_reg, count_reg, rd_data;
    logic        mem_grant, empty;
    logic        mem_request, tx_enable, rd_enable, tx_done;
    logic [31:0] mem_addr, mem_wr_data, words_left;
    int checks = 0;
    int errors = 0;

    dma_write_logic #(.ADDR_STEP(4)) dut (
        .clk(clk), .reset(reset), .ctrl_sig_reg(ctrl_sig_reg), .addr_reg(addr_reg),
        .count_reg(count_reg), .mem_request(mem_request), .mem_grant(mem_grant),
        .mem_addr(mem_addr), .tx_enable(tx_enable), .mem_wr_data(mem_wr_data),
        .empty(empty), .rd_enable(rd_enable), .rd_data(rd_data), .tx_done(tx_done),
        .words_left(words_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [31:0] c, input logic [31:0] a, input logic [31:0] n);
        ctrl_sig_reg = c;
        addr_reg = a;
        count_reg = n;
        #1;
    endtask

    task automatic fifo(input logic e, input logic [31:0] d);
        empty = e;
        rd_data = d;
        #1;
    endtask

    task automatic strobe(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [31:0] wl);
        chk({tag, ".tx_enable"}, 32'(tx_enable), 1);
        chk({tag, ".rd_enable"}, 32'(rd_enable), 1);
        chk({tag, ".mem_addr"}, mem_addr, a);
        chk({tag, ".data"}, mem_wr_data, d);
        chk({tag, ".words_left"}, words_left, wl);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".mem_request"}, 32'(mem_request), 0);
        chk({tag, ".mem_addr"}, mem_addr, 0);
        chk({tag, ".tx_enable"}, 32'(tx_enable), 0);
        chk({tag, ".mem_wr_data"}, mem_wr_data, 0);
        chk({tag, ".rd_enable"}, 32'(rd_enable), 0);
        chk({tag, ".tx_done"}, 32'(tx_done), 0);
        chk({tag, ".words_left"}, words_left, 0);
    endtask

    initial begin
        reset = 1;
        mem_grant = 0;
        ctrl_sig_reg = 32'd3;
        addr_reg = 0;
        count_reg = 0;
        empty = 1;
        rd_data = 32'hDEAD_BEEF;
        #3;
        all_zero("reset");
        tick();
        reset = 0;
        fifo(0, 32'hAAAA_0001);
        mem_grant = 1;
        tick();
        tick();
        chk("no_start_after_reset", 32'(mem_request), 0);
        cfg(0, 0, 0);
        tick();
        // fixed-address burst of three words
        cfg(3, 32'h1000, 3);
        tick();
        chk("fix.bus_req", 32'(mem_request), 1);
        chk("fix.bus_req_nostrobe", 32'(tx_enable), 0);
        chk("fix.bus_req_addr", mem_addr, 0);
        chk("fix.words_left", words_left, 3);
        tick();
        strobe("fix.w0", 32'h1000, 32'hAAAA_0001, 3);
        tick();
        fifo(0, 32'hBBBB_0002);
        strobe("fix.w1", 32'h1000, 32'hBBBB_0002, 2);
        tick();
        fifo(0, 32'hCCCC_0003);
        strobe("fix.w2", 32'h1000, 32'hCCCC_0003, 1);
        tick();
        fifo(1, 0);
        chk("fix.done_nostrobe", 32'(tx_enable), 0);
        chk("fix.done_req", 32'(mem_request), 0);
        chk("fix.done_wl", words_left, 0);
        chk("fix.done_txdone_low", 32'(tx_done), 0);
        tick();
        chk("fix.tx_done", 32'(tx_done), 1);
        tick();
        tick();
        chk("retrig.held_no_req", 32'(mem_request), 0);
        chk("retrig.tx_done_held", 32'(tx_done), 1);
        // increment with an empty stall
        cfg(0, 0, 0);
        tick();
        cfg(7, 32'h2000, 2);
        tick();
        chk("inc.tx_done_cleared", 32'(tx_done), 0);
        chk("inc.bus_req", 32'(mem_request), 1);
        tick();
        chk("inc.stall0_strobe", 32'(tx_enable), 0);
        chk("inc.stall0_pop", 32'(rd_enable), 0);
        chk("inc.stall0_req", 32'(mem_request), 1);
        chk("inc.stall0_addr", mem_addr, 32'h2000);
        chk("inc.stall0_data", mem_wr_data, 0);
        tick();
        chk("inc.stall1_strobe", 32'(tx_enable), 0);
        tick();
        chk("inc.stall2_strobe", 32'(tx_enable), 0);
        fifo(0, 32'hD000_0001);
        strobe("inc.w0", 32'h2000, 32'hD000_0001, 2);
        tick();
        fifo(0, 32'hD000_0002);
        strobe("inc.w1", 32'h2004, 32'hD000_0002, 1);
        tick();
        fifo(1, 0);
        chk("inc.done_wl", words_left, 0);
        tick();
        chk("inc.tx_done", 32'(tx_done), 1);
        // grant drop after first of four words
        cfg(0, 0, 0);
        tick();
        cfg(7, 32'h3000, 4);
        fifo(0, 32'hE000_0000);
        tick();
        tick();
        strobe("gl.w0", 32'h3000, 32'hE000_0000, 4);
        tick();
        mem_grant = 0;
        fifo(0, 32'hE000_0001);
        chk("gl.nogrant_strobe", 32'(tx_enable), 0);
        chk("gl.nogrant_pop", 32'(rd_enable), 0);
        chk("gl.nogrant_req", 32'(mem_request), 1);
        chk("gl.nogrant_wl", words_left, 3);
        tick();
        chk("gl.busreq_req", 32'(mem_request), 1);
        chk("gl.busreq_addr", mem_addr, 0);
        chk("gl.busreq_strobe", 32'(tx_enable), 0);
        mem_grant = 1;
        tick();
        strobe("gl.w1", 32'h3004, 32'hE000_0001, 3);
        tick();
        fifo(0, 32'hE000_0002);
        strobe("gl.w2", 32'h3008, 32'hE000_0002, 2);
        tick();
        fifo(0, 32'hE000_0003);
        strobe("gl.w3", 32'h300C, 32'hE000_0003, 1);
        tick();
        fifo(1, 0);
        chk("gl.wl_zero", words_left, 0);
        chk("gl.done_nostrobe", 32'(tx_enable), 0);
        tick();
        chk("gl.tx_done", 32'(tx_done), 1);
        // zero count goes straight to DONE
        cfg(0, 0, 0);
        tick();
        cfg(3, 32'h4000, 0);
        tick();
        chk("zero.no_req", 32'(mem_request), 0);
        chk("zero.tx_done_low", 32'(tx_done), 0);
        tick();
        chk("zero.tx_done", 32'(tx_done), 1);
        chk("zero.no_req2", 32'(mem_request), 0);
        // address wrap
        cfg(0, 0, 0);
        tick();
        cfg(7, 32'hFFFF_FFFC, 2);
        fifo(0, 32'h0F00_0001);
        tick();
        tick();
        strobe("wrap.w0", 32'hFFFF_FFFC, 32'h0F00_0001, 2);
        tick();
        fifo(0, 32'h0F00_0002);
        strobe("wrap.w1", 32'h0000_0000, 32'h0F00_0002, 1);
        tick();
        fifo(1, 0);
        tick();
        chk("wrap.tx_done", 32'(tx_done), 1);
        // abort mid-burst
        cfg(0, 0, 0);
        tick();
        cfg(3, 32'h5000, 4);
        fifo(0, 32'h5500_0001);
        tick();
        tick();
        strobe("abort.w0", 32'h5000, 32'h5500_0001, 4);
        tick();
        fifo(0, 32'h5500_0002);
        ctrl_sig_reg = 32'd2;
        #1;
        chk("abort.no_strobe", 32'(tx_enable), 0);
        chk("abort.no_pop", 32'(rd_enable), 0);
        tick();
        chk("abort.idle_req", 32'(mem_request), 0);
        chk("abort.tx_done", 32'(tx_done), 0);
        chk("abort.wl_kept", words_left, 3);
        // asynchronous reset during WRITE_DATA
        cfg(0, 0, 0);
        tick();
        cfg(3, 32'h6000, 5);
        tick();
        tick();
        chk("areset.pre_strobe", 32'(tx_enable), 1);
        #2;
        reset = 1;
        #1;
        all_zero("areset");
        tick();
        reset = 0;
        tick();
        tick();
        chk("areset.idle_no_req", 32'(mem_request), 0);
        chk("areset.no_strobe", 32'(tx_enable), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dma_write_logic.md
DMA_WRITE_LOGIC -- requirements
Module: dma_write_logic

Interface
REQ-001 SHALL have parameter ADDR_STEP, default 4, destination address increment per word when incrementing is enabled.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ctrl_sig_reg  input  32  bit0 dma_active; bit1 mode (1 = write, this block); bit2 inc_dst_addr (0 = fixed, 1 = increment); other bits ignored.
REQ-005 SHALL have port addr_reg  input  32  destination start address.
REQ-006 SHALL have port count_reg  input  32  number of words to transfer.
REQ-007 SHALL have port mem_request  output  1  bus request to arbiter.
REQ-008 SHALL have port mem_grant  input  1  bus grant from arbiter.
REQ-009 SHALL have port mem_addr  output  32  destination write address.
REQ-010 SHALL have port tx_enable  output  1  write strobe; mem_wr_data is valid this cycle.
REQ-011 SHALL have port mem_wr_data  output  32  word written to the destination.
REQ-012 SHALL have port empty  input  1  FIFO empty flag.
REQ-013 SHALL have port rd_enable  output  1  FIFO pop; the FIFO is first-word-fall-through, so rd_data is valid whenever empty=0.
REQ-014 SHALL have port rd_data  input  32  FIFO head word.
REQ-015 SHALL have port tx_done  output  1  completion flag (interrupt).
REQ-016 SHALL have port words_left  output  32  remaining word count.

Function
REQ-017 SHALL implement the states IDLE, BUS_REQ, WRITE_DATA and DONE, with a registered state and combinational outputs decoded from the state.
REQ-018 SHALL hold a registered armed flag, set while dma_active=0 and cleared at each start; a start requires armed=1, so a level-held dma_active never re-triggers.
REQ-019 A start SHALL occur in IDLE when dma_active=1, mode=1 and armed=1; on start, cur_addr<=addr_reg, cur_count<=count_reg, tx_done<=0, and the block moves to BUS_REQ.
REQ-020 On start with count_reg=0, the block SHALL go IDLE->DONE and SHALL NOT raise mem_request.
REQ-021 In BUS_REQ, mem_request SHALL be 1; the block SHALL move to WRITE_DATA when mem_grant=1, otherwise stay in BUS_REQ.
REQ-022 In WRITE_DATA, mem_request SHALL be 1 and mem_addr SHALL equal cur_addr; a transfer fires when mem_grant=1 and empty=0.
REQ-023 On a transfer cycle: tx_enable=1, rd_enable=1 and mem_wr_data=rd_data, all in the same cycle (zero latency); otherwise tx_enable=0, rd_enable=0 and mem_wr_data=0.
REQ-024 On each transfer, cur_count SHALL decrement by 1; cur_addr SHALL advance by ADDR_STEP if inc_dst_addr=1, else hold; address arithmetic is 32-bit modulo (0xFFFFFFFC+4 -> 0x00000000).
REQ-025 A transfer with cur_count=1 SHALL move the block to DONE; otherwise it stays in WRITE_DATA (burst).
REQ-026 In WRITE_DATA with mem_grant=0, the block SHALL return to BUS_REQ with no transfer; with empty=0 and no grant, nothing is popped.
REQ-027 In WRITE_DATA with empty=1 and mem_grant=1, the block SHALL hold the state and the bus, with no strobe.
REQ-028 If dma_active=0 or mode=0 in BUS_REQ or WRITE_DATA, the block SHALL abort to IDLE next cycle: no transfer that cycle, tx_done stays 0, cur_count is retained.
REQ-029 DONE SHALL last one cycle; tx_done<=1 on leaving DONE and is held until the next start or reset; then IDLE.
REQ-030 words_left SHALL equal cur_count.
REQ-031 inc_dst_addr SHALL be sampled live each transfer cycle.
REQ-032 mem_addr SHALL be 0 outside WRITE_DATA.

Reset
REQ-033 reset=1 SHALL asynchronously force state=IDLE, cur_addr=0, cur_count=0, tx_done=0 and armed=0.
REQ-034 While reset=1, all outputs SHALL read 0.
REQ-035 Reset mid-transfer SHALL abandon the transfer immediately, with no further strobes.
REQ-036 After release, a start SHALL require dma_active to be seen low for at least one cycle first.

Verification
REQ-037 Fixed address: ctrl=0b011, addr=0x1000, count=3, grant=1, FIFO holding A,B,C -> three consecutive strobes at 0x1000 with data A,B,C; tx_done=1 two cycles after the last strobe.
REQ-038 Increment plus empty stall: ctrl=0b111, addr=0x2000, count=2, FIFO empty for 3 cycles then 2 words -> strobes at 0x2000 and 0x2004 only after data arrives, with no strobe while empty=1.
REQ-039 Grant loss: drop mem_grant for 2 cycles after the first of 4 words -> BUS_REQ re-entered, mem_request stays 1, exactly 4 strobes in total, words_left reaches 0.
REQ-040 Zero count and wrap: count=0 -> tx_done=1 with mem_request never asserted; addr=0xFFFFFFFC, inc on, count=2 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-041 Abort and retrigger: clear ctrl bit0 mid-burst -> IDLE, tx_done=0; hold ctrl=0b011 after completion -> no second run until bit0 toggles low then high.
REQ-042 Async reset: assert reset between clock edges during WRITE_DATA -> all outputs 0 immediately, state IDLE.
